// File: rtl/clk_div_cfg_ctrl_if.sv
// Request/sleep/divider-control bundle between register file, sequencer and divider.
// o_clamped exists only when CLK_DIV_CFG_CLAMP_EN is defined.
interface clk_div_cfg_ctrl_if #(
  parameter int RATIO_W = 8
);
  logic               i_req_valid;
  logic [RATIO_W-1:0] i_req_ratio;
  logic               o_req_ready;
  logic               i_sleep;
  logic               o_clk_en;
  logic [RATIO_W-1:0] o_div_ratio;
  logic               o_locked;
  logic               o_busy;
`ifdef CLK_DIV_CFG_CLAMP_EN
  logic               o_clamped;

  modport master (
    output i_req_valid, i_req_ratio, i_sleep,
    input  o_req_ready, o_clk_en, o_div_ratio, o_locked, o_busy, o_clamped
  );
  modport slave (
    input  i_req_valid, i_req_ratio, i_sleep,
    output o_req_ready, o_clk_en, o_div_ratio, o_locked, o_busy, o_clamped
  );
`else
  modport master (
    output i_req_valid, i_req_ratio, i_sleep,
    input  o_req_ready, o_clk_en, o_div_ratio, o_locked, o_busy
  );
  modport slave (
    input  i_req_valid, i_req_ratio, i_sleep,
    output o_req_ready, o_clk_en, o_div_ratio, o_locked, o_busy
  );
`endif
endinterface

// File: rtl/clk_div_cfg_ctrl.sv
// Glitch-safe ratio/enable sequencer for the integer clock divider, with sleep gate.
// Optional ratio clamp to MAX_RATIO and sticky o_clamped under CLK_DIV_CFG_CLAMP_EN.
module clk_div_cfg_ctrl #(
  parameter int RATIO_W     = 8,
  parameter int RESET_RATIO = 1,
  parameter int SETTLE_CYC  = 4,
  parameter int MAX_RATIO   = 63
) (
  input logic               i_ref_clk,
  input logic               i_rst_n,
  clk_div_cfg_ctrl_if.slave bus
);

  if (SETTLE_CYC < 1 || MAX_RATIO >= (1 << RATIO_W) || RESET_RATIO >= (1 << RATIO_W)) begin : g_param_chk
    $error("clk_div_cfg_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {ST_RUN, ST_DRAIN, ST_LOAD, ST_LOCK, ST_SLEEP} state_t;

  localparam logic [RATIO_W-1:0] RST_RATIO   = RATIO_W'(RESET_RATIO);
  localparam logic [RATIO_W-1:0] SETTLE_LAST = RATIO_W'(SETTLE_CYC - 1);
  localparam logic [RATIO_W-1:0] MIN_DIV     = RATIO_W'(2);
  localparam logic [RATIO_W-1:0] ONE         = RATIO_W'(1);

  state_t             r_state, w_nxt_state;
  logic [RATIO_W-1:0] r_cnt, w_nxt_cnt;
  logic [RATIO_W-1:0] r_pend, w_nxt_pend;
  logic [RATIO_W-1:0] r_div_ratio, w_nxt_div_ratio;
  logic               r_clk_en, w_nxt_clk_en;
  logic               r_locked, w_nxt_locked;
  logic               r_req_ready, r_busy;
  logic               r_clamped, w_nxt_clamped;
  logic [RATIO_W-1:0] w_req_ratio;
  logic               w_clamp_hit;
  logic               w_accept, w_change;

`ifdef CLK_DIV_CFG_CLAMP_EN
  assign w_clamp_hit   = bus.i_req_ratio > RATIO_W'(MAX_RATIO);
  assign w_req_ratio   = w_clamp_hit ? RATIO_W'(MAX_RATIO) : bus.i_req_ratio;
  assign bus.o_clamped = r_clamped;
`else
  assign w_clamp_hit = 1'b0;
  assign w_req_ratio = bus.i_req_ratio;
`endif

  // Ready is only ever high in RUN; sleep still takes priority over a request.
  assign w_accept = bus.i_req_valid & r_req_ready & ~bus.i_sleep;
  assign w_change = w_accept & (w_req_ratio != r_div_ratio);

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_RUN;
    else          r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_RUN: begin
        if (bus.i_sleep)   w_nxt_state = ST_SLEEP;
        else if (w_change) w_nxt_state = ST_DRAIN;
      end
      ST_DRAIN: if (r_cnt == SETTLE_LAST) w_nxt_state = ST_LOAD;
      ST_LOAD:  w_nxt_state = (r_pend < MIN_DIV) ? ST_RUN : ST_LOCK;
      ST_LOCK:  if (r_cnt == r_div_ratio) w_nxt_state = ST_RUN;
      ST_SLEEP: if (!bus.i_sleep) w_nxt_state = (r_div_ratio >= MIN_DIV) ? ST_LOCK : ST_RUN;
      default:  w_nxt_state = ST_RUN;
    endcase
  end

  always_comb begin
    w_nxt_cnt       = r_cnt;
    w_nxt_pend      = r_pend;
    w_nxt_div_ratio = r_div_ratio;
    w_nxt_clk_en    = r_clk_en;
    w_nxt_locked    = r_locked;
    w_nxt_clamped   = r_clamped;
    case (r_state)
      ST_RUN: begin
        if (bus.i_sleep) begin
          w_nxt_clk_en = 1'b0;
          w_nxt_locked = 1'b0;
        end else if (w_accept) begin
          w_nxt_pend    = w_req_ratio;
          w_nxt_clamped = r_clamped | w_clamp_hit;
          if (w_change) begin
            w_nxt_clk_en = 1'b0;
            w_nxt_locked = 1'b0;
            w_nxt_cnt    = '0;
          end
        end
      end
      ST_DRAIN: begin
        w_nxt_cnt = r_cnt + ONE;
        if (r_cnt == SETTLE_LAST) w_nxt_div_ratio = r_pend;
      end
      ST_LOAD: begin
        // LOCK counts from 1 so lock lands exactly o_div_ratio cycles after enable.
        w_nxt_cnt = ONE;
        if (r_pend < MIN_DIV) w_nxt_locked = 1'b1;
        else                  w_nxt_clk_en = 1'b1;
      end
      ST_LOCK: begin
        w_nxt_cnt = r_cnt + ONE;
        if (r_cnt == r_div_ratio) w_nxt_locked = 1'b1;
      end
      ST_SLEEP: begin
        if (!bus.i_sleep) begin
          w_nxt_cnt = ONE;
          if (r_div_ratio >= MIN_DIV) w_nxt_clk_en = 1'b1;
          else                        w_nxt_locked = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_pend      <= RST_RATIO;
      r_div_ratio <= RST_RATIO;
      r_clk_en    <= (RESET_RATIO >= 2);
      r_locked    <= 1'b1;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_clamped   <= 1'b0;
    end else begin
      r_cnt       <= w_nxt_cnt;
      r_pend      <= w_nxt_pend;
      r_div_ratio <= w_nxt_div_ratio;
      r_clk_en    <= w_nxt_clk_en;
      r_locked    <= w_nxt_locked;
      r_req_ready <= (w_nxt_state == ST_RUN);
      r_busy      <= (w_nxt_state != ST_RUN);
      r_clamped   <= w_nxt_clamped;
    end
  end

  assign bus.o_req_ready = r_req_ready;
  assign bus.o_clk_en    = r_clk_en;
  assign bus.o_div_ratio = r_div_ratio;
  assign bus.o_locked    = r_locked;
  assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: timeline model checked every cycle plus directed literal checks.
// Build with CLK_DIV_CFG_CLAMP_EN defined to cover the clamp path.
module tb_clk_div_cfg_ctrl;
  localparam int RW = 8;
  localparam int RR = 1;
  localparam int SC = 4;
  localparam int MR = 63;

  logic i_ref_clk = 1'b0;
  logic i_rst_n   = 1'b0;
  always #5 i_ref_clk = ~i_ref_clk;

  clk_div_cfg_ctrl_if #(.RATIO_W(RW)) bus ();

  clk_div_cfg_ctrl #(.RATIO_W(RW), .RESET_RATIO(RR), .SETTLE_CYC(SC), .MAX_RATIO(MR)) dut (
    .i_ref_clk (i_ref_clk),
    .i_rst_n   (i_rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: describes the expected outputs as a timeline measured from the edge
  // where a sequence started, rather than as a state machine.
  typedef enum {M_RUN, M_CHG, M_SLP, M_WAKE} mmode_t;
  mmode_t m_mode;
  int m_ratio, m_new, m_t0, cyc;
  bit m_clamped;

  function automatic int clampf(input int r);
`ifdef CLK_DIV_CFG_CLAMP_EN
    return (r > MR) ? MR : r;
`else
    return r;
`endif
  endfunction

  function automatic int chg_len(input int p);
    return (p < 2) ? SC + 1 : SC + 1 + p;
  endfunction

  function automatic int wake_len(input int r);
    return (r >= 2) ? r : 0;
  endfunction

  always @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_mode = M_RUN; m_ratio = RR; m_new = RR; m_t0 = 0; cyc = 0; m_clamped = 0;
    end else begin
      cyc++;
      if (m_mode == M_CHG && (cyc - 1) >= m_t0 + chg_len(m_new)) begin
        m_ratio = m_new;
        m_mode  = M_RUN;
      end
      if (m_mode == M_WAKE && (cyc - 1) >= m_t0 + wake_len(m_ratio)) m_mode = M_RUN;
      case (m_mode)
        M_RUN: begin
          if (bus.i_sleep) begin
            m_mode = M_SLP; m_t0 = cyc;
          end else if (bus.i_req_valid) begin
            int p;
            p = clampf(int'(bus.i_req_ratio));
            if (p != int'(bus.i_req_ratio)) m_clamped = 1;
            if (p != m_ratio) begin
              m_mode = M_CHG; m_new = p; m_t0 = cyc;
            end
          end
        end
        M_SLP: if (!bus.i_sleep) begin
          m_mode = M_WAKE; m_t0 = cyc;
        end
        default: ;
      endcase
    end
  end

  always @(negedge i_ref_clk) begin
    int d, e_rat, e_en, e_lk, e_rdy, e_busy;
    if (i_rst_n) begin
      e_rat = m_ratio; e_en = (m_ratio >= 2); e_lk = 1; e_rdy = 1; e_busy = 0;
      case (m_mode)
        M_CHG: begin
          d = cyc - m_t0;
          if (d >= chg_len(m_new)) begin
            e_rat = m_new; e_en = (m_new >= 2);
          end else begin
            e_lk = 0; e_rdy = 0; e_busy = 1;
            e_rat = (d >= SC) ? m_new : m_ratio;
            e_en  = (d >= SC + 1);
          end
        end
        M_SLP: begin
          e_en = 0; e_lk = 0; e_rdy = 0; e_busy = 1;
        end
        M_WAKE: begin
          d = cyc - m_t0;
          if (d < wake_len(m_ratio)) begin
            e_en = 1; e_lk = 0; e_rdy = 0; e_busy = 1;
          end
        end
        default: ;
      endcase
      chk("cyc_ratio", int'(bus.o_div_ratio), e_rat);
      chk("cyc_clk_en", int'(bus.o_clk_en), e_en);
      chk("cyc_locked", int'(bus.o_locked), e_lk);
      chk("cyc_ready", int'(bus.o_req_ready), e_rdy);
      chk("cyc_busy", int'(bus.o_busy), e_busy);
`ifdef CLK_DIV_CFG_CLAMP_EN
      chk("cyc_clamped", int'(bus.o_clamped), int'(m_clamped));
`endif
    end
  end

  int rec_en[16], rec_rat[16], rec_lk[16], rec_rdy[16], rec_busy[16];

  // Present one request for one cycle, then record the outputs after each of n edges.
  task automatic req_rec(input int ratio, input int n);
    @(negedge i_ref_clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_ratio = RW'(ratio);
    for (int i = 0; i < n; i++) begin
      @(negedge i_ref_clk);
      bus.i_req_valid = 1'b0;
      rec_en[i]   = int'(bus.o_clk_en);
      rec_rat[i]  = int'(bus.o_div_ratio);
      rec_lk[i]   = int'(bus.o_locked);
      rec_rdy[i]  = int'(bus.o_req_ready);
      rec_busy[i] = int'(bus.o_busy);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((bus.o_busy || bus.i_sleep) && n < 400) begin
      @(negedge i_ref_clk);
      n++;
    end
    chk(name, int'(bus.o_busy), 0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_ratio"}, int'(bus.o_div_ratio), RR);
    chk({name, "_clk_en"}, int'(bus.o_clk_en), 0);
    chk({name, "_locked"}, int'(bus.o_locked), 1);
    chk({name, "_ready"}, int'(bus.o_req_ready), 1);
    chk({name, "_busy"}, int'(bus.o_busy), 0);
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_ratio = '0;
    bus.i_sleep     = 1'b0;
    #23;
    chk_reset_vals("rst");
    @(negedge i_ref_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_ref_clk);

    // 1 -> 6: worked timing
    req_rec(6, 13);
    for (int i = 0; i <= 4; i++) chk("r6_en_low", rec_en[i], 0);
    chk("r6_ratio_e3", rec_rat[3], 1);
    chk("r6_ratio_e4", rec_rat[4], 6);
    chk("r6_en_e5", rec_en[5], 1);
    chk("r6_lock_e10", rec_lk[10], 0);
    chk("r6_lock_e11", rec_lk[11], 1);
    chk("r6_rdy_e10", rec_rdy[10], 0);
    chk("r6_rdy_e11", rec_rdy[11], 1);

    // Same ratio: accepted, nothing drops
    req_rec(6, 5);
    for (int i = 0; i < 5; i++) begin
      chk("same_en", rec_en[i], 1);
      chk("same_lock", rec_lk[i], 1);
      chk("same_busy", rec_busy[i], 0);
    end

    // 6 -> 0: bypass
    req_rec(0, 8);
    chk("byp_ratio_e3", rec_rat[3], 6);
    chk("byp_ratio_e4", rec_rat[4], 0);
    for (int i = 0; i < 8; i++) chk("byp_en", rec_en[i], 0);
    chk("byp_lock_e4", rec_lk[4], 0);
    chk("byp_lock_e5", rec_lk[5], 1);
    chk("byp_busy_e5", rec_busy[5], 0);

    // 0 -> 4, then sleep for 10 cycles
    req_rec(4, 2);
    wait_idle("idle_r4");
    @(negedge i_ref_clk);
    bus.i_sleep = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_ref_clk);
      chk("slp_en", int'(bus.o_clk_en), 0);
      chk("slp_lock", int'(bus.o_locked), 0);
      chk("slp_rdy", int'(bus.o_req_ready), 0);
      chk("slp_ratio", int'(bus.o_div_ratio), 4);
    end
    bus.i_sleep = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_ref_clk);
      rec_en[i] = int'(bus.o_clk_en);
      rec_lk[i] = int'(bus.o_locked);
    end
    chk("wake_en_e0", rec_en[0], 1);
    chk("wake_lock_e3", rec_lk[3], 0);
    chk("wake_lock_e4", rec_lk[4], 1);

    // Sleep and request together: sleep wins, ratio untouched
    @(negedge i_ref_clk);
    bus.i_sleep = 1'b1; bus.i_req_valid = 1'b1; bus.i_req_ratio = RW'(9);
    @(negedge i_ref_clk);
    bus.i_req_valid = 1'b0;
    repeat (2) @(negedge i_ref_clk);
    bus.i_sleep = 1'b0;
    wait_idle("idle_slpreq");
    chk("slpreq_ratio", int'(bus.o_div_ratio), 4);

    // Sleep raised mid-sequence is deferred until RUN
    req_rec(10, 2);
    bus.i_sleep = 1'b1;
    repeat (20) @(negedge i_ref_clk);
    chk("defer_ratio", int'(bus.o_div_ratio), 10);
    chk("defer_asleep_en", int'(bus.o_clk_en), 0);
    bus.i_sleep = 1'b0;
    wait_idle("idle_defer");

    // Reset pulse during LOCK
    req_rec(8, 7);
    chk("lockphase_en", int'(bus.o_clk_en), 1);
    #2 i_rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(negedge i_ref_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_ref_clk);

`ifdef CLK_DIV_CFG_CLAMP_EN
    req_rec(200, 2);
    wait_idle("idle_clamp");
    chk("clamp_ratio", int'(bus.o_div_ratio), 63);
    chk("clamp_flag", int'(bus.o_clamped), 1);
    req_rec(8, 2);
    wait_idle("idle_clamp8");
    chk("clamp_ratio8", int'(bus.o_div_ratio), 8);
    chk("clamp_sticky", int'(bus.o_clamped), 1);
`else
    req_rec(200, 2);
    wait_idle("idle_big");
    chk("big_ratio", int'(bus.o_div_ratio), 200);
`endif
    repeat (2) @(negedge i_ref_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
